// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester (cpu / dbg) round-robin arbiter in front of a
//               single-port registered memory. Each granted access takes
//               IDLE -> ACCESS -> RESP and ends with a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  // processor requester
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  // debug / program-loader requester
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_done,
  output logic [DATA_W-1:0] dbg_rdata,
  // memory side
  output logic              MemRead,
  output logic              MemWrite,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic c_OWN_CPU = 1'b0;
  localparam logic c_OWN_DBG = 1'b1;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_owner;       // requester of the transaction in flight
  logic                r_last_owner;  // requester served most recently
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                w_grant_cpu;
  logic                w_grant_dbg;

  // Round-robin: on a tie, the requester that was not served last wins.
  assign w_grant_cpu = cpu_req & (~dbg_req | (r_last_owner == c_OWN_DBG));
  assign w_grant_dbg = dbg_req & ~w_grant_cpu;

  // State register; reset returns to IDLE immediately, which also drops strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and memory-side outputs; bus is driven only in ACCESS.
  always_comb begin
    w_next_state   = r_state;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    mem_address    = '0;
    mem_write_data = '0;
    busy           = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (cpu_req || dbg_req) begin
          w_next_state = ACCESS;
        end
      end
      ACCESS: begin
        MemRead        = ~r_we;
        MemWrite       = r_we;
        mem_address    = r_addr;
        mem_write_data = r_wdata;
        w_next_state   = RESP;
      end
      RESP: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Grant latching, round-robin history, done pulses and read-data capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner      <= c_OWN_CPU;
      r_last_owner <= c_OWN_DBG;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      cpu_done     <= 1'b0;
      dbg_done     <= 1'b0;
      cpu_rdata    <= '0;
      dbg_rdata    <= '0;
    end else begin
      cpu_done <= 1'b0;
      dbg_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_cpu) begin
            r_owner <= c_OWN_CPU;
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
          end else if (w_grant_dbg) begin
            r_owner <= c_OWN_DBG;
            r_we    <= dbg_we;
            r_addr  <= dbg_addr;
            r_wdata <= dbg_wdata;
          end
        end
        RESP: begin
          // Registered memory: read data is stable during RESP.
          r_last_owner <= r_owner;
          if (r_owner == c_OWN_CPU) begin
            cpu_done <= 1'b1;
            if (!r_we) begin
              cpu_rdata <= mem_read_data;
            end
          end else begin
            dbg_done <= 1'b1;
            if (!r_we) begin
              dbg_rdata <= mem_read_data;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Self-checking bench for mem_arbiter with a registered memory
//               model and an expected-completion scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_done;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0, dbg_we = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic [DW-1:0] dbg_wdata = '0;
  logic          dbg_done;
  logic [DW-1:0] dbg_rdata;
  logic          MemRead, MemWrite;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic [DW-1:0] mem_read_data;
  logic          busy;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_done(cpu_done), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_done(dbg_done), .dbg_rdata(dbg_rdata),
    .MemRead(MemRead), .MemWrite(MemWrite), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Initial memory image: address XOR 0xB5 (so mem[0x10] = 0xA5).
  function automatic logic [7:0] init_val(input logic [7:0] a);
    return a ^ 8'hB5;
  endfunction

  // Registered memory model, reloaded with the initial image while in reset.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(8'(i));
      mem_read_data <= '0;
    end else begin
      if (MemWrite) mem[mem_address] <= mem_write_data;
      if (MemRead)  mem_read_data <= mem[mem_address];
    end
  end

  typedef struct packed {
    logic          who;   // 0 = cpu, 1 = dbg
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Bus monitor and scoreboard consumer.
  always @(negedge clk) begin
    checks++;
    if (MemRead && MemWrite) begin
      errors++;
      $display("FAIL strobe_excl MemRead=%b MemWrite=%b required not both high", MemRead, MemWrite);
    end
    checks++;
    if (!MemRead && !MemWrite && (mem_address !== '0 || mem_write_data !== '0)) begin
      errors++;
      $display("FAIL idle_bus addr=%h wdata=%h required 00/00", mem_address, mem_write_data);
    end
    if (cpu_done === 1'b1 || dbg_done === 1'b1) begin
      checks++;
      if (cpu_done && dbg_done) begin
        errors++;
        $display("FAIL done_excl cpu_done=1 dbg_done=1 required at most one");
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done cpu_done=%b dbg_done=%b required none", cpu_done, dbg_done);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.who !== dbg_done || (dbg_done ? dbg_rdata : cpu_rdata) !== mon_e.data) begin
          errors++;
          $display("FAIL sb_done who=%b rdata=%h required who=%b rdata=%h", dbg_done,
                   (dbg_done ? dbg_rdata : cpu_rdata), mon_e.who, mon_e.data);
        end
      end
    end
  end

  // Waits up to budget negedges for the given requester's done; -1 on timeout.
  task automatic wait_done(input logic who, input int budget, output int cycles);
    cycles = -1;
    for (int i = 1; i <= budget && cycles < 0; i++) begin
      @(negedge clk);
      if ((who ? dbg_done : cpu_done) === 1'b1) cycles = i;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({MemRead, MemWrite, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_strobes rd/wr/busy=%b required 000", {MemRead, MemWrite, busy});
    end
    checks++;
    if ({cpu_done, dbg_done, cpu_rdata, dbg_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs done=%b%b rdata=%h/%h required 0", cpu_done, dbg_done, cpu_rdata, dbg_rdata);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_req busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_read();
    int c;
    cpu_we = 1'b0; cpu_addr = 8'h10; cpu_req = 1'b1;
    sb.push_back('{1'b0, 8'hA5});
    @(negedge clk);
    checks++;
    if (MemRead !== 1'b1 || MemWrite !== 1'b0 || mem_address !== 8'h10 || busy !== 1'b1) begin
      errors++;
      $display("FAIL read_access rd=%b wr=%b addr=%h busy=%b required 1 0 10 1", MemRead, MemWrite, mem_address, busy);
    end
    @(negedge clk);
    checks++;
    if (MemRead !== 1'b0 || cpu_done !== 1'b0) begin
      errors++;
      $display("FAIL read_resp rd=%b done=%b required 0 0", MemRead, cpu_done);
    end
    wait_done(1'b0, 4, c);
    cpu_req = 1'b0;
    checks++;
    if (c !== 1 || cpu_rdata !== 8'hA5 || dbg_done !== 1'b0) begin
      errors++;
      $display("FAIL read_done latency=%0d rdata=%h dbg_done=%b required 1 a5 0", c, cpu_rdata, dbg_done);
    end
    @(negedge clk);
    checks++;
    if (cpu_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b required 0 0", cpu_done, busy);
    end
  endtask

  task automatic test_write_readback();
    int c;
    dbg_we = 1'b1; dbg_addr = 8'h20; dbg_wdata = 8'h3C; dbg_req = 1'b1;
    sb.push_back('{1'b1, 8'h00});
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b1 || MemRead !== 1'b0 || mem_address !== 8'h20 || mem_write_data !== 8'h3C) begin
      errors++;
      $display("FAIL write_access wr=%b rd=%b addr=%h wdata=%h required 1 0 20 3c", MemWrite, MemRead, mem_address, mem_write_data);
    end
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL write_one_cycle wr=%b required 0", MemWrite);
    end
    wait_done(1'b1, 4, c);
    checks++;
    if (c !== 1 || dbg_rdata !== 8'h00) begin
      errors++;
      $display("FAIL write_done latency=%0d rdata=%h required 1 00", c, dbg_rdata);
    end
    // req still high at the edge after done: new request, now a read
    dbg_we = 1'b0;
    sb.push_back('{1'b1, 8'h3C});
    wait_done(1'b1, 6, c);
    dbg_req = 1'b0;
    checks++;
    if (c !== 3 || dbg_rdata !== 8'h3C) begin
      errors++;
      $display("FAIL readback latency=%0d rdata=%h required 3 3c", c, dbg_rdata);
    end
  endtask

  task automatic test_contention();
    int   t [4];
    logic w [4];
    int   n;
    n = 0;
    reset = 1'b1;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h02;
    sb.push_back('{1'b0, init_val(8'h01)});
    sb.push_back('{1'b1, init_val(8'h02)});
    sb.push_back('{1'b0, init_val(8'h01)});
    sb.push_back('{1'b1, init_val(8'h02)});
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 16 && n < 4; i++) begin
      @(negedge clk);
      if (cpu_done === 1'b1 || dbg_done === 1'b1) begin
        t[n] = i; w[n] = dbg_done; n++;
      end
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL contention_count dones=%0d required 4", n);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k < n && (t[k] !== 3 * (k + 1) || w[k] !== k[0])) begin
        errors++;
        $display("FAIL contention_order idx=%0d cycle=%0d who=%b required cycle=%0d who=%b", k, t[k], w[k], 3 * (k + 1), k[0]);
      end
    end
  endtask

  task automatic test_abandoned();
    int dn;
    dn = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
    sb.push_back('{1'b0, 8'hA5});
    @(negedge clk);
    checks++;
    if (MemRead !== 1'b1 || mem_address !== 8'h10) begin
      errors++;
      $display("FAIL abandon_access rd=%b addr=%h required 1 10", MemRead, mem_address);
    end
    cpu_req = 1'b0; cpu_addr = 8'h55;
    repeat (6) begin
      @(negedge clk);
      if (cpu_done === 1'b1) dn++;
    end
    checks++;
    if (dn !== 1 || cpu_rdata !== 8'hA5) begin
      errors++;
      $display("FAIL abandon_done pulses=%0d rdata=%h required 1 a5", dn, cpu_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    int c;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h30; dbg_wdata = 8'h77;
    @(negedge clk);
    checks++;
    if (MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL mid_access wr=%b required 1", MemWrite);
    end
    reset = 1'b1;
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || busy !== 1'b0 || dbg_done !== 1'b0 || dbg_rdata !== 8'h00 || cpu_rdata !== 8'h00) begin
      errors++;
      $display("FAIL async_reset wr=%b busy=%b dbg_done=%b rdata=%h/%h required 0 0 0 00/00",
               MemWrite, busy, dbg_done, cpu_rdata, dbg_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
    sb.push_back('{1'b0, init_val(8'h01)});
    wait_done(1'b0, 6, c);
    cpu_req = 1'b0;
    checks++;
    if (c !== 3 || cpu_rdata !== init_val(8'h01)) begin
      errors++;
      $display("FAIL post_reset_read latency=%0d rdata=%h required 3 %h", c, cpu_rdata, init_val(8'h01));
    end
  endtask

  task automatic test_back_to_back();
    int c;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h01;
    for (int k = 1; k <= 3; k++) sb.push_back('{1'b0, init_val(8'(k))});
    for (int k = 1; k <= 3; k++) begin
      wait_done(1'b0, 6, c);
      checks++;
      if (c !== 3 || cpu_rdata !== init_val(8'(k))) begin
        errors++;
        $display("FAIL b2b_%0d spacing=%0d rdata=%h required 3 %h", k, c, cpu_rdata, init_val(8'(k)));
      end
      if (k < 3) cpu_addr = 8'(k + 1);
      else cpu_req = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_contention();
    test_abandoned();
    test_reset_mid_access();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++;
      $display("FAIL sb_drain pending=%0d required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout time=%0t required finish earlier", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the memory data width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have ports cpu_req / cpu_we, input, 1 bit each: processor access request and write enable.
REQ-006 The block SHALL have ports cpu_addr (ADDR_W) / cpu_wdata (DATA_W), input: processor address and write data.
REQ-007 The block SHALL have ports cpu_done (1) / cpu_rdata (DATA_W), output: processor completion pulse and read data.
REQ-008 The block SHALL have ports dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_done and dbg_rdata, with the same widths and meanings as the cpu_* ports, for the debug/program-loader requester.
REQ-009 The block SHALL have ports MemRead / MemWrite, output, 1 bit each: memory strobes.
REQ-010 The block SHALL have ports mem_address (ADDR_W) / mem_write_data (DATA_W), output: address and write data to memory.
REQ-011 The block SHALL have port mem_read_data, input, DATA_W: memory read data, valid on the clock edge that ends the MemRead cycle (registered memory).
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-014 In IDLE with neither request high, the FSM SHALL stay in IDLE and all memory strobes SHALL be low.
REQ-015 In IDLE with exactly one request high, that requester SHALL win; the FSM SHALL latch its we, addr and wdata and go to ACCESS on the next edge.
REQ-016 In IDLE with both requests high, the requester not served most recently (last_owner) SHALL win; this is round-robin.
REQ-017 In ACCESS, the block SHALL drive MemRead = !we_latched and MemWrite = we_latched, and mem_address and mem_write_data from the latches, for exactly one cycle; the FSM SHALL then go to RESP.
REQ-018 In RESP, strobes SHALL be low; on the RESP-exit edge the block SHALL register the winner's done = 1, set last_owner = winner and go to IDLE.
REQ-019 For a read, the winner's rdata SHALL be loaded from mem_read_data on the RESP-exit edge.
REQ-020 For a write, the winner's rdata SHALL hold its previous value.
REQ-021 The loser's rdata SHALL be unchanged, and its done SHALL stay low.
REQ-022 done SHALL be a registered one-cycle pulse, high only in the cycle after RESP.
REQ-023 Latency: request sampled at edge N leads to a memory strobe in cycle N→N+1 and done high in cycle N+2→N+3; peak throughput is one access per 3 cycles.
REQ-024 A requester SHALL hold req and its operands stable until it sees done.
REQ-025 A req still high at the edge after done SHALL be treated as a new request.
REQ-026 Dropping req after the IDLE grant SHALL NOT abort the transaction; the latched transaction completes and done still pulses.
REQ-027 Operand changes after the grant SHALL be ignored, because they are latched.
REQ-028 A request that arrives while busy SHALL wait.
REQ-029 A waiting requester SHALL be granted no later than the next IDLE decision after the current transaction, so worst-case wait is one transaction.
REQ-030 mem_address and mem_write_data SHALL be 0 outside ACCESS.
REQ-031 At most one of MemRead and MemWrite SHALL be high at any time.

Reset
REQ-032 On reset assertion, the block SHALL immediately and asynchronously return to IDLE with MemRead = MemWrite = 0, cpu_done = dbg_done = 0, cpu_rdata = dbg_rdata = 0, busy = 0, all latches = 0 and last_owner = dbg, so the processor wins the first tie.
REQ-033 Reset asserted during ACCESS or RESP SHALL abandon the transaction: no done pulse, no rdata update, and the strobe drops without waiting for a clock edge.
REQ-034 After reset deasserts, the first IDLE decision SHALL occur on the first rising edge at which reset is low.

Verification
REQ-035 Single read: memory[0x10]=0xA5, cpu_req=1, cpu_we=0, cpu_addr=0x10 at edge N -> MemRead=1 with mem_address=0x10 for exactly cycle N→N+1, cpu_done=1 for cycle N+2→N+3 only, cpu_rdata=0xA5, dbg_done=0.
REQ-036 Write then read-back: dbg writes 0x3C to 0x20 -> MemWrite=1 for one cycle with mem_write_data=0x3C and dbg_rdata unchanged; a following dbg read of 0x20 -> dbg_rdata=0x3C.
REQ-037 Contention: both reqs held high from reset release -> grant order cpu, dbg, cpu, dbg; done pulses every 3 cycles alternating; MemRead and MemWrite never high together.
REQ-038 Abandoned request: cpu_req pulsed high for one cycle at an IDLE edge, then cpu_addr changed -> access still uses the original address and cpu_done still pulses once.
REQ-039 Reset mid-access: reset asserted halfway through ACCESS of a dbg write -> MemWrite falls immediately, busy=0, no dbg_done; after release, a pending cpu read is served normally.
REQ-040 Back-to-back single requester: cpu_req held high with 3 reads (addresses 0x01, 0x02, 0x03) -> three done pulses at 3-cycle spacing, rdata matches memory each time.
